// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives IM, and handles stall, redirect and HLT drain.
// Optional PC_BOUNDS_CHK_EN halts fetch with fetch_err when the PC leaves IM's address range.
module if_fetch_ctrl #(
  parameter int unsigned          ADDR_W     = 16,
  parameter int unsigned          INSTR_W    = 17,
  parameter logic [ADDR_W-1:0]    RESET_PC   = '0,
  parameter int unsigned          IMEM_DEPTH = 2048,
  parameter logic [4:0]           HLT_OP     = 5'b11111,
  parameter logic [INSTR_W-1:0]   NOP_INSTR  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_IF,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic [INSTR_W-1:0] instr_IM,
  output logic [ADDR_W-1:0]  addr,
  output logic               rd_en,
  output logic [INSTR_W-1:0] instr_IF,
  output logic [ADDR_W-1:0]  pc_IF,
  output logic [ADDR_W-1:0]  pc_inc_IF,
  output logic               vld_IF,
  output logic               halted,
  output logic               fetch_err
);

  typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

  if (IMEM_DEPTH == 0 || IMEM_DEPTH > (2 ** ADDR_W)) begin : gen_depth_chk
    $error("IMEM_DEPTH must be in 1..2**ADDR_W");
  end

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [1:0]         drain_cnt_q, drain_cnt_d;
  logic               halted_q, halted_d;
  logic               oob;
  logic               run;
  logic               is_hlt;

`ifdef PC_BOUNDS_CHK_EN
  logic fetch_err_q, fetch_err_d;
  assign oob       = (32'(pc_q) >= IMEM_DEPTH);
  assign fetch_err = fetch_err_q;
`else
  assign oob       = 1'b0;
  assign fetch_err = 1'b0;
`endif

  assign run       = (state_q == StRun);
  assign addr      = pc_q;
  assign pc_IF     = pc_q;
  assign pc_inc_IF = pc_q + ADDR_W'(1);
  // Reset forces a read so IM presents RESET_PC's word as soon as rst drops.
  assign rd_en     = rst | (run & ~stall_IF & ~oob);
  assign vld_IF    = run & ~br_taken & ~rst & ~oob;
  assign instr_IF  = vld_IF ? instr_IM : NOP_INSTR;
  assign halted    = halted_q;
  assign is_hlt    = vld_IF && (instr_IM[15:11] == HLT_OP);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drain_cnt_d = drain_cnt_q;
    halted_d    = halted_q;
`ifdef PC_BOUNDS_CHK_EN
    fetch_err_d = fetch_err_q;
`endif
    unique case (state_q)
      StRun: begin
        if (br_taken) begin
          pc_d = br_target;
        end else if (oob) begin
          state_d  = StHalt;
          halted_d = 1'b1;
`ifdef PC_BOUNDS_CHK_EN
          fetch_err_d = 1'b1;
`endif
        end else if (!stall_IF) begin
          if (is_hlt) begin
            state_d     = StDrain;
            drain_cnt_d = 2'd2;
          end else begin
            pc_d = pc_inc_IF;
          end
        end
      end
      StDrain: begin
        // HLT was speculative until older instructions resolve; a redirect revives fetch.
        if (br_taken) begin
          pc_d        = br_target;
          state_d     = StRun;
          drain_cnt_d = 2'd0;
        end else if (!stall_IF) begin
          if (drain_cnt_q == 2'd1) begin
            state_d     = StHalt;
            halted_d    = 1'b1;
            drain_cnt_d = 2'd0;
          end else begin
            drain_cnt_d = drain_cnt_q - 2'd1;
          end
        end
      end
      StHalt: begin
      end
      default: begin
        state_d = StHalt;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      pc_q        <= RESET_PC;
      drain_cnt_q <= 2'd0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= halted_d;
    end
  end

`ifdef PC_BOUNDS_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_err_q <= 1'b0;
    end else begin
      fetch_err_q <= fetch_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a negedge-reading IM model.
// Bounds-check steps are compiled only when PC_BOUNDS_CHK_EN is defined.
module tb_if_fetch_ctrl;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 17;
  localparam logic [INSTR_W-1:0] HLT_WORD = 17'h0F800;

  logic               clk = 1'b0;
  logic               rst;
  logic               stall_IF;
  logic               br_taken;
  logic [ADDR_W-1:0]  br_target;
  logic [INSTR_W-1:0] instr_IM;
  logic [ADDR_W-1:0]  addr;
  logic               rd_en;
  logic [INSTR_W-1:0] instr_IF;
  logic [ADDR_W-1:0]  pc_IF;
  logic [ADDR_W-1:0]  pc_inc_IF;
  logic               vld_IF;
  logic               halted;
  logic               fetch_err;

  int total = 0;
  int bad   = 0;

  if_fetch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .stall_IF  (stall_IF),
    .br_taken  (br_taken),
    .br_target (br_target),
    .instr_IM  (instr_IM),
    .addr      (addr),
    .rd_en     (rd_en),
    .instr_IF  (instr_IF),
    .pc_IF     (pc_IF),
    .pc_inc_IF (pc_inc_IF),
    .vld_IF    (vld_IF),
    .halted    (halted),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  // IM contents: HLT at word 12, otherwise a non-HLT opcode tagged with the address.
  function automatic logic [INSTR_W-1:0] im_word(input logic [ADDR_W-1:0] a);
    if (a == 16'd12) return HLT_WORD;
    return 17'h10800 | {6'd0, a[10:0]};
  endfunction

  logic [INSTR_W-1:0] im_q = '0;
  always @(negedge clk) if (rd_en) im_q <= im_word(addr);
  assign instr_IM = im_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lets the negedge IM read land before outputs are sampled.
  task automatic settle();
    #5;
  endtask

  initial begin
    rst = 1'b1; stall_IF = 1'b0; br_taken = 1'b0; br_target = '0;
    tick();
    settle();
    chk("rst_addr",   32'(addr),      32'h0);
    chk("rst_rd_en",  32'(rd_en),     32'h1);
    chk("rst_vld",    32'(vld_IF),    32'h0);
    chk("rst_halted", 32'(halted),    32'h0);
    chk("rst_err",    32'(fetch_err), 32'h0);
    tick();
    rst = 1'b0;

    // Straight-line fetch 0..3
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("run_addr",  32'(addr),      32'(i));
      chk("run_vld",   32'(vld_IF),    32'h1);
      chk("run_inc",   32'(pc_inc_IF), 32'(i + 1));
      chk("run_instr", 32'(instr_IF),  32'(im_word(16'(i))));
      tick();
    end
    settle();
    tick();

    // Stall three cycles at pc=5: IM output holds word 4
    stall_IF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_addr",  32'(addr),     32'h5);
      chk("stall_rden",  32'(rd_en),    32'h0);
      chk("stall_instr", 32'(instr_IF), 32'(im_word(16'd4)));
      tick();
    end
    stall_IF = 1'b0;
    settle();
    chk("unstall_instr", 32'(instr_IF), 32'(im_word(16'd5)));
    tick();
    settle();
    chk("resume_addr", 32'(addr), 32'h6);
    tick();
    tick();
    tick();

    // Branch at pc=9 together with stall: branch wins, bubble out
    br_taken = 1'b1; br_target = 16'h0040; stall_IF = 1'b1;
    settle();
    chk("br_pc9",    32'(addr),     32'h9);
    chk("br_vld",    32'(vld_IF),   32'h0);
    chk("br_instr",  32'(instr_IF), 32'(17'h00000));
    tick();
    br_taken = 1'b0; stall_IF = 1'b0;
    settle();
    chk("br_dest",   32'(addr),     32'h40);
    chk("br_dvld",   32'(vld_IF),   32'h1);
    chk("br_dinstr", 32'(instr_IF), 32'(im_word(16'h40)));
    tick();

    // Redirect to 12 where HLT sits; drain two cycles then halt
    br_taken = 1'b1; br_target = 16'd12;
    tick();
    br_taken = 1'b0;
    settle();
    chk("hlt_vld",   32'(vld_IF),   32'h1);
    chk("hlt_instr", 32'(instr_IF), 32'(HLT_WORD));
    tick();
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("drain_vld",   32'(vld_IF),   32'h0);
      chk("drain_rden",  32'(rd_en),    32'h0);
      chk("drain_halt",  32'(halted),   32'h0);
      chk("drain_addr",  32'(addr),     32'd12);
      chk("drain_instr", 32'(instr_IF), 32'h0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      br_taken = i[0]; br_target = 16'h0077; stall_IF = i[1];
      settle();
      chk("halt_flag", 32'(halted), 32'h1);
      chk("halt_addr", 32'(addr),   32'd12);
      chk("halt_vld",  32'(vld_IF), 32'h0);
      chk("halt_rden", 32'(rd_en),  32'h0);
      tick();
    end
    br_taken = 1'b0; stall_IF = 1'b0;

    // Mid-operation reset, then HLT cancelled by a branch during drain
    rst = 1'b1;
    settle();
    chk("rst2_halted", 32'(halted), 32'h0);
    chk("rst2_addr",   32'(addr),   32'h0);
    tick();
    rst = 1'b0;
    br_taken = 1'b1; br_target = 16'd12;
    tick();
    br_taken = 1'b0;
    settle();
    chk("hlt2_vld", 32'(vld_IF), 32'h1);
    tick();
    br_taken = 1'b1; br_target = 16'h0020;
    settle();
    chk("cancel_vld", 32'(vld_IF), 32'h0);
    tick();
    br_taken = 1'b0;
    settle();
    chk("cancel_addr",   32'(addr),   32'h20);
    chk("cancel_halted", 32'(halted), 32'h0);
    chk("cancel_vld2",   32'(vld_IF), 32'h1);
    tick();

`ifdef PC_BOUNDS_CHK_EN
    // Out-of-range fetch: redirect in that cycle still wins
    br_taken = 1'b1; br_target = 16'h0800;
    tick();
    br_target = 16'h0030;
    settle();
    chk("oob_vld0",  32'(vld_IF), 32'h0);
    tick();
    br_taken = 1'b0;
    settle();
    chk("oob_redir", 32'(addr),      32'h30);
    chk("oob_noerr", 32'(fetch_err), 32'h0);
    tick();
    br_taken = 1'b1; br_target = 16'h0800;
    tick();
    br_taken = 1'b0;
    settle();
    chk("oob_vld",  32'(vld_IF),    32'h0);
    chk("oob_rden", 32'(rd_en),     32'h0);
    chk("oob_err0", 32'(fetch_err), 32'h0);
    tick();
    settle();
    chk("oob_err",  32'(fetch_err), 32'h1);
    chk("oob_halt", 32'(halted),    32'h1);
    tick();
    rst = 1'b1;
    settle();
    chk("oob_rst_err",  32'(fetch_err), 32'h0);
    chk("oob_rst_halt", 32'(halted),    32'h0);
    tick();
    rst = 1'b0;
`else
    // No bounds check: PC wraps at 16'hFFFF
    br_taken = 1'b1; br_target = 16'hFFFF;
    tick();
    br_taken = 1'b0;
    settle();
    chk("wrap_vld", 32'(vld_IF),    32'h1);
    chk("wrap_inc", 32'(pc_inc_IF), 32'h0);
    chk("wrap_err", 32'(fetch_err), 32'h0);
    tick();
    settle();
    chk("wrap_addr", 32'(addr), 32'h0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
